// File: rtl/alarm_pkg.sv
// alarm_pkg: shared widths, FSM state type and lowest-index picker for the alarm trigger
package alarm_pkg;
  localparam int NUM_ALARMS = 5;
  localparam int BCD_W = 8;
  localparam int SEC_W = 9;
  localparam int ID_W = 3;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} alarm_state_t;
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_ALARMS-1:0] v);
    lowest_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (v[k]) lowest_idx = ID_W'(k);
  endfunction
endpackage

// File: rtl/alarm_trigger_match.sv
// alarm_match: BCD equality compare of one enabled alarm against the current time
module alarm_match
  import alarm_pkg::*;
(
  input  logic [BCD_W-1:0] alarm_hour,
  input  logic [BCD_W-1:0] alarm_min,
  input  logic [BCD_W-1:0] alarm_sec,
  input  logic [BCD_W-1:0] cur_hour,
  input  logic [BCD_W-1:0] cur_min,
  input  logic [BCD_W-1:0] cur_sec,
  input  logic             en,
  output logic             hit
);
  assign hit = en && alarm_hour == cur_hour && alarm_min == cur_min && alarm_sec == cur_sec;
endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm compare, ring/snooze FSM and pending queue (snooze built only with ALARM_SNOOZE_EN)
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sec_tick,
  input  logic [BCD_W-1:0]            cur_hour,
  input  logic [BCD_W-1:0]            cur_min,
  input  logic [BCD_W-1:0]            cur_sec,
  input  logic [NUM_ALARMS*BCD_W-1:0] alarm_hour,
  input  logic [NUM_ALARMS*BCD_W-1:0] alarm_min,
  input  logic [NUM_ALARMS*BCD_W-1:0] alarm_sec,
  input  logic [NUM_ALARMS-1:0]       alarm_en,
  input  logic                        stop,
  input  logic                        snooze,
  output logic                        ring,
  output logic [ID_W-1:0]             ring_id,
  output logic                        snoozing,
  output logic [NUM_ALARMS-1:0]       pending
);
  alarm_state_t state, state_n;
  logic [SEC_W-1:0] sec_cnt, sec_cnt_n;
  logic [ID_W-1:0] ring_id_n, pick;
  logic [NUM_ALARMS-1:0] hit, match, cand, pending_n;
  logic snz_ok;
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_match
    alarm_match u_match (
      .alarm_hour(alarm_hour[BCD_W*i +: BCD_W]),
      .alarm_min (alarm_min[BCD_W*i +: BCD_W]),
      .alarm_sec (alarm_sec[BCD_W*i +: BCD_W]),
      .cur_hour  (cur_hour),
      .cur_min   (cur_min),
      .cur_sec   (cur_sec),
      .en        (alarm_en[i]),
      .hit       (hit[i])
    );
  end
  assign match = sec_tick ? hit : '0;
  assign cand = match | pending;
  assign pick = lowest_idx(cand);
  always_comb begin
    state_n = state;
    sec_cnt_n = sec_cnt;
    ring_id_n = ring_id;
    pending_n = pending;
    if (state == IDLE) begin
      if (|cand) begin
        state_n = RINGING;
        ring_id_n = pick;
        pending_n = cand & ~(NUM_ALARMS'(1) << pick);
        sec_cnt_n = SEC_W'(RING_SECS - 1);
      end
    end else begin
      pending_n = pending | (match & ~(NUM_ALARMS'(1) << ring_id));
      if (stop) state_n = IDLE;
      else if (state == RINGING && snz_ok) begin
        state_n = SNOOZE;
        sec_cnt_n = SEC_W'(SNOOZE_SECS - 1);
      end else if (sec_tick) begin
        state_n = sec_cnt != '0 ? state : state == RINGING ? IDLE : RINGING;
        sec_cnt_n = sec_cnt != '0 ? sec_cnt - 1'b1 : state == SNOOZE ? SEC_W'(RING_SECS - 1) : '0;
      end
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      sec_cnt <= '0;
      ring_id <= '0;
      pending <= '0;
      ring <= 1'b0;
    end else begin
      state <= state_n;
      sec_cnt <= sec_cnt_n;
      ring_id <= ring_id_n;
      pending <= pending_n;
      ring <= state_n == RINGING;
    end
`ifdef ALARM_SNOOZE_EN
  logic [2:0] snz_cnt;
  assign snz_ok = snooze && snz_cnt < 3'(MAX_SNOOZE);
  always_ff @(posedge clock)
    if (reset) begin
      snz_cnt <= '0;
      snoozing <= 1'b0;
    end else begin
      snz_cnt <= state == IDLE ? '0 : snz_cnt + 3'(state == RINGING && !stop && snz_ok);
      snoozing <= state_n == SNOOZE;
    end
`else
  logic unused_snooze;
  assign snz_ok = 1'b0;
  assign snoozing = 1'b0;
  assign unused_snooze = snooze ^ (MAX_SNOOZE != 0);
`endif
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: scoreboard bench for alarm_trigger with RING_SECS=4, SNOOZE_SECS=2, MAX_SNOOZE=1
module tb_alarm_trigger;
  logic clock = 1'b0;
  logic reset, sec_tick, stop, snooze;
  logic [7:0] cur_hour, cur_min, cur_sec;
  logic [39:0] alarm_hour, alarm_min, alarm_sec;
  logic [4:0] alarm_en;
  logic ring, snoozing;
  logic [2:0] ring_id;
  logic [4:0] pending;
  int checks = 0;
  int fails = 0;
  localparam logic [23:0] T0800 = 24'h080000;
  localparam logic [23:0] T0600 = 24'h060000;
  localparam logic [23:0] T0730 = 24'h073000;
  localparam logic [23:0] T1200 = 24'h120000;
  localparam logic [23:0] TOTH  = 24'h000001;
  typedef struct packed {
    logic       ring;
    logic [2:0] id;
    logic       snzg;
    logic [4:0] pend;
  } exp_t;
  typedef struct packed {
    logic [3:0]  ctl;
    logic [23:0] t;
    logic [4:0]  en;
    exp_t        e;
  } row_t;
  exp_t sb[$];

  alarm_trigger #(.RING_SECS(4), .SNOOZE_SECS(2), .MAX_SNOOZE(1)) dut (
    .clock(clock), .reset(reset), .sec_tick(sec_tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .alarm_en(alarm_en), .stop(stop), .snooze(snooze),
    .ring(ring), .ring_id(ring_id), .snoozing(snoozing), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic drive_row(input row_t r);
    {reset, sec_tick, stop, snooze} = r.ctl;
    {cur_hour, cur_min, cur_sec} = r.t;
    alarm_en = r.en;
    sb.push_back(r.e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    row_t r [3];
    exp_t e, got;
    r = '{'{4'b1100, T0730, 5'b00100, exp_t'(10'd0)},
          '{4'b1000, TOTH,  5'b00100, exp_t'(10'd0)},
          '{4'b0000, TOTH,  5'b00100, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, ring_id, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL reset[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_basic;
    row_t r [7];
    exp_t e, got;
    r = '{'{4'b0100, T0730, 5'b00100, exp_t'({1'b1, 3'd2, 1'b0, 5'b0})},
          '{4'b0000, TOTH,  5'b00100, exp_t'({1'b1, 3'd2, 1'b0, 5'b0})},
          '{4'b0100, TOTH,  5'b00100, exp_t'({1'b1, 3'd2, 1'b0, 5'b0})},
          '{4'b0100, TOTH,  5'b00100, exp_t'({1'b1, 3'd2, 1'b0, 5'b0})},
          '{4'b0100, TOTH,  5'b00100, exp_t'({1'b1, 3'd2, 1'b0, 5'b0})},
          '{4'b0100, TOTH,  5'b00100, exp_t'(10'd0)},
          '{4'b0000, TOTH,  5'b00100, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL basic[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_priority;
    row_t r [9];
    exp_t e, got;
    r = '{'{4'b0100, T0600, 5'b01010, exp_t'({1'b1, 3'd1, 1'b0, 5'b01000})},
          '{4'b0000, TOTH,  5'b01010, exp_t'({1'b1, 3'd1, 1'b0, 5'b01000})},
          '{4'b0010, TOTH,  5'b01010, exp_t'({1'b0, 3'd0, 1'b0, 5'b01000})},
          '{4'b0000, TOTH,  5'b01010, exp_t'({1'b1, 3'd3, 1'b0, 5'b00000})},
          '{4'b0100, T0600, 5'b01010, exp_t'({1'b1, 3'd3, 1'b0, 5'b00010})},
          '{4'b0010, TOTH,  5'b01010, exp_t'({1'b0, 3'd0, 1'b0, 5'b00010})},
          '{4'b0000, TOTH,  5'b01010, exp_t'({1'b1, 3'd1, 1'b0, 5'b00000})},
          '{4'b0010, TOTH,  5'b01010, exp_t'(10'd0)},
          '{4'b0000, TOTH,  5'b01010, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL priority[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_stop_tick;
    row_t r [4];
    exp_t e, got;
    r = '{'{4'b0100, T0730, 5'b00100, exp_t'({1'b1, 3'd2, 1'b0, 5'b0})},
          '{4'b0110, T1200, 5'b10100, exp_t'({1'b0, 3'd0, 1'b0, 5'b10000})},
          '{4'b0000, TOTH,  5'b10100, exp_t'({1'b1, 3'd4, 1'b0, 5'b0})},
          '{4'b0010, TOTH,  5'b10100, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL stop_tick[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_enable;
    row_t r [3];
    exp_t e, got;
    r = '{'{4'b0100, T1200, 5'b01111, exp_t'(10'd0)},
          '{4'b0100, T1200, 5'b10000, exp_t'({1'b1, 3'd4, 1'b0, 5'b0})},
          '{4'b0010, TOTH,  5'b10000, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL enable[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze;
    row_t r [11];
    exp_t e, got;
    r = '{'{4'b0100, T0800, 5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0001, TOTH,  5'b00001, exp_t'({1'b0, 3'd0, 1'b1, 5'b0})},
          '{4'b0100, TOTH,  5'b00001, exp_t'({1'b0, 3'd0, 1'b1, 5'b0})},
          '{4'b0100, TOTH,  5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0001, TOTH,  5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0101, TOTH,  5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0011, TOTH,  5'b00001, exp_t'(10'd0)},
          '{4'b0000, TOTH,  5'b00001, exp_t'(10'd0)},
          '{4'b0100, T0800, 5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0011, TOTH,  5'b00001, exp_t'(10'd0)},
          '{4'b0000, TOTH,  5'b00001, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL snooze[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_reset_mid;
    row_t r [6];
    exp_t e, got;
    r = '{'{4'b0100, T0800, 5'b00111, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0100, T0600, 5'b00111, exp_t'({1'b1, 3'd0, 1'b0, 5'b00010})},
          '{4'b0001, TOTH,  5'b00111, exp_t'({1'b0, 3'd0, 1'b1, 5'b00010})},
          '{4'b0100, T0730, 5'b00111, exp_t'({1'b0, 3'd0, 1'b1, 5'b00110})},
          '{4'b1000, TOTH,  5'b00111, exp_t'(10'd0)},
          '{4'b0000, TOTH,  5'b00111, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL reset_mid[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask
`else
  task automatic test_snooze;
    row_t r [4];
    exp_t e, got;
    r = '{'{4'b0100, T0800, 5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0001, TOTH,  5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0101, TOTH,  5'b00001, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0010, TOTH,  5'b00001, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL snooze_off[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_reset_mid;
    row_t r [5];
    exp_t e, got;
    r = '{'{4'b0100, T0800, 5'b00111, exp_t'({1'b1, 3'd0, 1'b0, 5'b0})},
          '{4'b0100, T0600, 5'b00111, exp_t'({1'b1, 3'd0, 1'b0, 5'b00010})},
          '{4'b0100, T0730, 5'b00111, exp_t'({1'b1, 3'd0, 1'b0, 5'b00110})},
          '{4'b1000, TOTH,  5'b00111, exp_t'(10'd0)},
          '{4'b0000, TOTH,  5'b00111, exp_t'(10'd0)}};
    foreach (r[k]) begin
      drive_row(r[k]);
      e = sb.pop_front();
      got = {ring, (e.ring | e.snzg) ? ring_id : 3'd0, snoozing, pending};
      checks++;
      if (got !== e) begin fails++; $display("FAIL reset_mid[%0d] got=%b exp=%b", k, got, e); end
    end
  endtask
`endif

  initial begin
    alarm_hour = {8'h12, 8'h06, 8'h07, 8'h06, 8'h08};
    alarm_min  = {8'h00, 8'h00, 8'h30, 8'h00, 8'h00};
    alarm_sec  = '0;
    {reset, sec_tick, stop, snooze} = 4'b1000;
    {cur_hour, cur_min, cur_sec} = TOTH;
    alarm_en = '0;
    test_reset;
    test_basic;
    test_priority;
    test_stop_tick;
    test_enable;
    test_snooze;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
